bfm_apbslave_ws: RTL and testbench



---
 rtl/bfm_apbslave_ws_pkg.sv | 6 +
 rtl/bfm_apbslave_ram.sv | 16 +
 rtl/bfm_apbslave_ws.sv | 61 ++++++
 tb/tb_bfm_apbslave_ws.sv | 112 +++++++++++
 4 files changed

// File: rtl/bfm_apbslave_ws_pkg.sv
// bfm_apbslave_ws_pkg: shared FSM encoding, CTRL offset and WAIT field width for the APB wait-state slave
package bfm_apbslave_ws_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [11:0] CTRL_OFF = 12'hFFC;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/bfm_apbslave_ram.sv
// bfm_apbslave_ram: single-port word RAM, sync read (clk, we, addr[MEM_AWIDTH], wdata[32] -> rdata[32]), no reset
module bfm_apbslave_ram #(
  parameter int MEM_AWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AWIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**MEM_AWIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/bfm_apbslave_ws.sv
// bfm_apbslave_ws: APB slave with RAM + CTRL wait-state register (PCLK, PRESET, PSEL, PADDR, PWRITE, PENABLE, PWDATA -> PRDATA, PREADY, PSLVERR)
module bfm_apbslave_ws
  import bfm_apbslave_ws_pkg::*;
#(
  parameter int MEM_AWIDTH = 8,
  parameter int WAIT_INIT  = 2,
  parameter int TPD        = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);
  state_t                state;
  logic [WAIT_W-1:0]     cnt, wait_q;
  logic [MEM_AWIDTH-1:0] lat_addr, ram_addr;
  logic                  lat_write, lat_ctrl, lat_err;
  logic [31:0]           ram_rdata;
  logic [9:0]            woff;
  logic                  is_ram, is_ctrl, setup, ram_we, unused;
  assign woff     = PADDR[11:2];
  assign is_ctrl  = PADDR[11:0] == CTRL_OFF;
  assign is_ram   = (woff >> MEM_AWIDTH) == '0;
  assign setup    = (state == IDLE) & PSEL & ~PENABLE;
  assign PREADY   = (state == ACCESS) & (cnt == '0) & PSEL & PENABLE;
  assign PSLVERR  = PREADY & lat_err;
  assign PRDATA   = (PREADY & ~lat_write & ~lat_err) ? (lat_ctrl ? {{(32-WAIT_W){1'b0}}, wait_q} : ram_rdata) : '0;
  assign ram_we   = PREADY & lat_write & ~lat_err & ~lat_ctrl;
  assign ram_addr = (state == ACCESS) ? lat_addr : PADDR[MEM_AWIDTH+1:2];
  assign unused   = ^{PADDR[31:12], 32'(TPD)};
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      wait_q <= WAIT_W'(WAIT_INIT);
    end else if (state == IDLE) begin
      if (setup) begin
        state     <= ACCESS;
        cnt       <= wait_q;
        lat_addr  <= PADDR[MEM_AWIDTH+1:2];
        lat_write <= PWRITE;
        lat_ctrl  <= is_ctrl;
        lat_err   <= (PADDR[1:0] != 2'b00) | ~(is_ram | is_ctrl);
      end
    end else if (~PSEL | PREADY) begin
      state <= IDLE;
      if (PREADY & lat_write & lat_ctrl & ~lat_err) wait_q <= PWDATA[WAIT_W-1:0];
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
  bfm_apbslave_ram #(.MEM_AWIDTH(MEM_AWIDTH)) u_ram (
    .clk(PCLK), .we(ram_we), .addr(ram_addr), .wdata(PWDATA), .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_bfm_apbslave_ws.sv
// tb_bfm_apbslave_ws: directed scoreboard bench for the APB wait-state slave
module tb_bfm_apbslave_ws;
  import bfm_apbslave_ws_pkg::*;
  localparam int TO = 40;
  localparam logic [31:0] CTRL = 32'(CTRL_OFF);
  logic        PCLK = 0, PRESET = 1, PSEL = 0, PWRITE = 0, PENABLE = 0;
  logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
  logic        PREADY, PSLVERR;
  int          checks = 0, errors = 0, wait_m = 2;
  time         last_done = 0, prev_done = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  always #5 PCLK = ~PCLK;
  bfm_apbslave_ws dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] rexp, input logic err);
    exp_t e;
    int   lat = 0;
    sb.push_back('{rexp, err, wait_m + 1});
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1 PENABLE = 1;
    forever begin
      lat++;
      @(negedge PCLK);
      if (PREADY === 1'b1 || lat >= TO) break;
      @(posedge PCLK); #1;
    end
    e = sb.pop_front();
    check({tag, ".lat"}, 32'(lat), 32'(e.lat));
    check({tag, ".ready"}, 32'(PREADY), 32'd1);
    check({tag, ".err"}, 32'(PSLVERR), 32'(e.err));
    check({tag, ".rdata"}, PRDATA, e.rdata);
    prev_done = last_done;
    last_done = $time;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    if (wr && !err && addr[11:0] == CTRL_OFF) wait_m = 32'(data[3:0]);
  endtask
  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    check("rst.ready", 32'(PREADY), 32'd0);
    check("rst.err", 32'(PSLVERR), 32'd0);
    check("rst.rdata", PRDATA, 32'd0);
    PRESET = 0;
    xfer("ctrl_init", 0, CTRL, 0, 32'd2, 0);
    xfer("ctrl_w0", 1, CTRL, 0, 0, 0);
    xfer("w004", 1, 32'h004, 32'hDEADBEEF, 0, 0);
    xfer("r004", 0, 32'h004, 0, 32'hDEADBEEF, 0);
    xfer("w000", 1, 32'h000, 32'h11111111, 0, 0);
    xfer("ctrl_w5", 1, CTRL, 32'hABCDEF05, 0, 0);
    xfer("r000_ws5", 0, 32'h000, 0, 32'h11111111, 0);
    xfer("ctrl_r5", 0, CTRL, 0, 32'h00000005, 0);
    xfer("ctrl_w0b", 1, CTRL, 0, 0, 0);
    xfer("r800", 0, 32'h800, 0, 0, 1);
    xfer("w002", 1, 32'h002, 32'h55555555, 0, 1);
    xfer("r000_keep", 0, 32'h000, 0, 32'h11111111, 0);
    xfer("ctrl_w1", 1, CTRL, 32'd1, 0, 0);
    xfer("w010", 1, 32'h010, 32'hA0A0A0A0, 0, 0);
    xfer("w014", 1, 32'h014, 32'h14141414, 0, 0);
    check("b2b.gap", 32'(last_done - prev_done), 32'd30);
    xfer("r010", 0, 32'h010, 0, 32'hA0A0A0A0, 0);
    xfer("r014", 0, 32'h014, 0, 32'h14141414, 0);
    xfer("w020", 1, 32'h020, 32'hCAFE0020, 0, 0);
    xfer("ctrl_w3", 1, CTRL, 32'd3, 0, 0);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h020; PWDATA = 32'h0BAD0BAD;
    @(posedge PCLK); #1 PENABLE = 1;
    @(negedge PCLK);
    check("rst_mid.wait1", 32'(PREADY), 32'd0);
    check("rst_mid.rdata", PRDATA, 32'd0);
    @(posedge PCLK); #1 PRESET = 1;
    @(negedge PCLK);
    check("rst_mid.wait2", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1 PRESET = 0; PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    check("rst_mid.after", 32'(PREADY), 32'd0);
    wait_m = 2;
    @(posedge PCLK); #1;
    xfer("r020_old", 0, 32'h020, 0, 32'hCAFE0020, 0);
    xfer("ctrl_rinit", 0, CTRL, 0, 32'd2, 0);
    xfer("w030", 1, 32'h030, 32'h30303030, 0, 0);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h030; PWDATA = 32'hBADBAD00;
    @(posedge PCLK); #1 PENABLE = 1;
    @(negedge PCLK);
    check("abort.wait", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    check("abort.drop", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    xfer("r030_abort", 0, 32'h030, 0, 32'h30303030, 0);
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h030; PWDATA = 32'h5A5A5A5A;
    repeat (2) begin
      @(negedge PCLK);
      check("stray.ready", 32'(PREADY), 32'd0);
      @(posedge PCLK); #1;
    end
    PSEL = 0; PENABLE = 0;
    xfer("r030_stray", 0, 32'h030, 0, 32'h30303030, 0);
    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
